tag_resolver: RTL and testbench
===============================

Name: tag_resolver

Overview:
- Downstream consumer of the associative array's per-row compare result (`tag_row`).
- Accumulates successive compare results into a tag register using load, AND or OR.
- Counts the matching rows bit-serially, then hands out matched row addresses lowest-first, one per request.
- `match_addr` drives the array's row read-address (`addr_output_Row`) so the controller can read each responder.

Parameters:
- DATA_DEPTH, 16, number of rows / tag bits.
- ADDR_WIDTH_CAM, 8, width of row address and match count; must satisfy 2^ADDR_WIDTH_CAM > DATA_DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstIn  input  1  asynchronous, active-low reset.
- tag_row  input  DATA_DEPTH  per-row match vector from the array.
- cmp_valid  input  1  one-cycle strobe: `tag_row` is valid this cycle.
- acc_mode  input  2  00 load, 01 AND, 10 OR, 11 hold (strobe ignored, no restart).
- clr_tags  input  1  synchronous clear of the tag register; aborts any operation.
- next_req  input  1  pop the current match.
- match_valid  output  1  `match_addr` holds a valid responder.
- match_addr  output  ADDR_WIDTH_CAM  lowest set tag index.
- match_cnt  output  ADDR_WIDTH_CAM  remaining responders.
- any_match  output  1  `match_cnt` != 0, valid outside COUNT.
- busy  output  1  high in COUNT.
- done  output  1  one-cycle pulse when the tag set is exhausted.

Behaviour:
- Reset (rstIn=0, asynchronous):
  - All of the following are 0: tag register T, scan index, every output.
  - State = IDLE.
  - Reset is honoured in any state, including mid-COUNT or mid-READY. No partial state survives.
- Accumulate: on a cycle with cmp_valid=1 and acc_mode!=11, the next T is:
  - load: `tag_row`
  - AND: `T & tag_row`
  - OR: `T | tag_row`
- Accumulate side effects, from any state:
  - Scan index is cleared, `match_cnt` is cleared, state goes to COUNT.
  - A strobe arriving during COUNT or READY aborts that activity and restarts counting.
- clr_tags has priority over cmp_valid in the same cycle. Effect: T=0, `match_cnt`=0, `match_valid`=0, state IDLE, no done pulse.
- States:
  - IDLE:
    - `busy`=0, `match_valid`=0.
    - Waits for an accumulate strobe.
  - COUNT:
    - `busy`=1, `match_valid`=0.
    - Each cycle examines T[idx], increments `match_cnt` if set, then increments idx.
    - Lasts exactly DATA_DEPTH cycles (idx 0..DATA_DEPTH-1).
    - After the last index: go to READY if the count is nonzero. Otherwise go to IDLE and pulse `done` for one cycle.
  - READY:
    - `match_valid`=1.
    - `match_addr` = index of the lowest set bit of T (combinational priority encode, registered output).
    - On next_req: clear that bit of T and decrement `match_cnt`.
    - `match_addr` shows the next lowest set bit on the following cycle.
    - The pop that removes the last bit goes to IDLE, with `match_valid`=0 and a one-cycle `done` pulse on the next cycle.
- Latency:
  - cmp_valid at cycle N: T updated at N+1.
  - COUNT occupies cycles N+1 .. N+DATA_DEPTH.
  - `match_valid`/`match_cnt` valid from cycle N+DATA_DEPTH+1.
- Ignored and unchanged cases:
  - next_req outside READY is ignored.
  - `match_cnt` never underflows.
  - `match_addr` holds its last value when `match_valid`=0.
- next_req and cmp_valid in the same READY cycle: the accumulate wins and the pop is discarded (T computed from the un-popped T).
- Output hold in IDLE: `any_match` and `match_cnt` keep their final values (0 after exhaustion) until the next accumulate or clr.

Test Plan:
- Reset: rstIn low mid-stream → all outputs 0, state IDLE. After release, `busy` stays 0 with no strobe.
- Load then pop all: load `tag_row`=16'h8421 → `busy` high for 16 cycles, then `match_cnt`=4, `match_addr`=0.
  - Three pops step `match_addr` 5, 10, 15.
  - A fourth pop drops `match_valid` and pulses `done` once.
- AND accumulate: load 16'hFF00, wait for READY, then AND 16'h0F0F → `match_cnt`=4, first `match_addr`=8.
- Empty result: load 16'h0000 → after 16 COUNT cycles `done` pulses, `match_valid` never asserts, `any_match`=0.
- Abort and priority:
  - OR 16'h0001 strobed at COUNT cycle 7 of a 16'hF000 load → COUNT restarts, final `match_cnt`=5.
  - clr_tags together with cmp_valid → T=0, IDLE, no `done` pulse.
- Asynchronous reset mid-READY with `match_cnt`=3 → outputs 0 immediately, not at the next clock edge.

Source files
------------

// File: rtl/tag_resolver.sv
// -----------------------------------------------------------------------------
// tag_resolver
//
// Reads the per-row compare result of the associative array and folds it
// into a tag register T. The fold is a load, an AND or an OR. After each fold
// it counts the set tags one row per cycle. It then hands out the matching row
// addresses, lowest first, one address per request.
//
// Ports
//   clk          rising-edge clock
//   rstIn        asynchronous, active-low reset
//   tag_row      per-row match vector from the array (DATA_DEPTH bits)
//   cmp_valid    one-cycle strobe: tag_row is valid this cycle
//   acc_mode     00 load, 01 AND, 10 OR, 11 hold (strobe ignored)
//   clr_tags     synchronous clear of T; beats cmp_valid, aborts everything
//   next_req     pop the responder currently shown on match_addr
//   match_valid  match_addr holds a valid responder (READY state)
//   match_addr   index of the lowest set tag; drives the array row address
//   match_cnt    responders remaining (counts up while scanning)
//   any_match    match_cnt != 0
//   busy         high while the bit-serial count runs
//   done         one-cycle pulse when the tag set is exhausted
//   state_dbg    current FSM state (0 idle, 1 count, 2 ready)
//
// Handshake: a pop is taken on a rising edge where match_valid and next_req
// are both high. The consumer may hold next_req high to pop on consecutive
// cycles. next_req is ignored while match_valid is low. A new accumulate
// strobe or clr_tags in the same cycle discards the pop.
// -----------------------------------------------------------------------------
module tag_resolver #(
   parameter int DATA_DEPTH     = 16,
   // Must satisfy 2**ADDR_WIDTH_CAM > DATA_DEPTH so that the full count fits.
   parameter int ADDR_WIDTH_CAM = 8
) (
   input  logic                      clk,
   input  logic                      rstIn,
   input  logic [DATA_DEPTH-1:0]     tag_row,
   input  logic                      cmp_valid,
   input  logic [1:0]                acc_mode,
   input  logic                      clr_tags,
   input  logic                      next_req,
   output logic                      match_valid,
   output logic [ADDR_WIDTH_CAM-1:0] match_addr,
   output logic [ADDR_WIDTH_CAM-1:0] match_cnt,
   output logic                      any_match,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_READY = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH_CAM-1:0] LAST_IDX = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
   localparam logic [ADDR_WIDTH_CAM-1:0] ONE      = ADDR_WIDTH_CAM'(1);

   state_t                    state_q, state_d;
   logic [DATA_DEPTH-1:0]     t_q, t_d;
   logic [ADDR_WIDTH_CAM-1:0] idx_q, idx_d;
   logic [ADDR_WIDTH_CAM-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH_CAM-1:0] addr_q, addr_d;
   logic                      done_q, done_d;

   // Priority encoder: the index of the lowest set bit (0 when none is set).
   function automatic logic [ADDR_WIDTH_CAM-1:0] lowest_set(input logic [DATA_DEPTH-1:0] v);
      logic [ADDR_WIDTH_CAM-1:0] r;
      r = '0;
      for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
         if (v[i]) r = ADDR_WIDTH_CAM'(i);
      end
      return r;
   endfunction

   logic                      acc_fire;
   logic [DATA_DEPTH-1:0]     acc_t;
   logic [DATA_DEPTH-1:0]     scan_vec;
   logic [ADDR_WIDTH_CAM-1:0] cnt_inc;
   logic [DATA_DEPTH-1:0]     popped_t;

   // Hold mode (11) ignores the strobe, so the current activity is not restarted.
   assign acc_fire = cmp_valid && (acc_mode != 2'b11);

   always_comb begin
      acc_t = t_q;
      case (acc_mode)
         2'b00:   acc_t = tag_row;
         2'b01:   acc_t = t_q & tag_row;
         2'b10:   acc_t = t_q | tag_row;
         default: acc_t = t_q;
      endcase
   end

   // Bit-serial scan: shift T so that the bit under examination lands at bit 0.
   // This avoids an index wider than the vector needs.
   assign scan_vec = t_q >> idx_q;
   assign cnt_inc  = cnt_q + ADDR_WIDTH_CAM'(scan_vec[0]);

   // T with the responder currently shown removed.
   assign popped_t = t_q & ~(DATA_DEPTH'(1) << addr_q);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      done_d  = 1'b0;

      if (clr_tags) begin
         // The clear overrides any strobe or pop in the same cycle.
         // It does not pulse done.
         t_d     = '0;
         idx_d   = '0;
         cnt_d   = '0;
         state_d = S_IDLE;
      end else if (acc_fire) begin
         // A strobe from any state restarts the count.
         // A pop in the same cycle is discarded, so the fold uses the un-popped T.
         t_d     = acc_t;
         idx_d   = '0;
         cnt_d   = '0;
         state_d = S_COUNT;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Wait for an accumulate strobe.
               // match_cnt, any_match and match_addr hold their values.
            end
            S_COUNT: begin
               cnt_d = cnt_inc;
               idx_d = idx_q + ONE;
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (cnt_inc != '0) begin
                     state_d = S_READY;
                     addr_d  = lowest_set(t_q);
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            S_READY: begin
               if (next_req) begin
                  t_d = popped_t;
                  if (cnt_q != '0) cnt_d = cnt_q - ONE;
                  if (popped_t == '0) begin
                     // The last responder is gone.
                     // match_addr keeps the address it last showed.
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     addr_d = lowest_set(popped_t);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstIn) begin
      if (!rstIn) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // Every output is taken straight from a flop.
   // An asynchronous reset therefore clears the outputs at once.
   assign match_valid = (state_q == S_READY);
   assign busy        = (state_q == S_COUNT);
   assign match_addr  = addr_q;
   assign match_cnt   = cnt_q;
   assign any_match   = (cnt_q != '0);
   assign done        = done_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_tag_resolver.sv
// -----------------------------------------------------------------------------
// tb_tag_resolver
//
// Drives directed and random accumulate/pop traffic into tag_resolver.
// The reference model keeps T as a plain 16-bit vector. Each responder the
// DUT should show is the lowest set bit of that vector, with the popcount as
// the remaining count. A monitor process compares every new presentation and
// every done pulse against the expected queue.
// -----------------------------------------------------------------------------
module tb_tag_resolver;

   localparam int DEPTH = 16;
   localparam int AW    = 8;

   // ---------------- clock / reset ----------------
   logic            clk;
   logic            rstIn;
   logic [DEPTH-1:0] tag_row;
   logic            cmp_valid;
   logic [1:0]      acc_mode;
   logic            clr_tags;
   logic            next_req;
   logic            match_valid;
   logic [AW-1:0]   match_addr;
   logic [AW-1:0]   match_cnt;
   logic            any_match;
   logic            busy;
   logic            done;
   logic [1:0]      state_dbg;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   tag_resolver #(.DATA_DEPTH(DEPTH), .ADDR_WIDTH_CAM(AW)) dut (
      .clk         (clk),
      .rstIn       (rstIn),
      .tag_row     (tag_row),
      .cmp_valid   (cmp_valid),
      .acc_mode    (acc_mode),
      .clr_tags    (clr_tags),
      .next_req    (next_req),
      .match_valid (match_valid),
      .match_addr  (match_addr),
      .match_cnt   (match_cnt),
      .any_match   (any_match),
      .busy        (busy),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int              errors = 0;
   int              checks = 0;
   logic [15:0]     exp_q[$];        // {addr, cnt} per expected presentation
   int              exp_done_cnt = 0;
   logic [DEPTH-1:0] m_t = '0;        // reference tag set
   bit              m_ready = 1'b0;  // reference: responders are on offer

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int lowest_of(input logic [DEPTH-1:0] v);
      for (int i = 0; i < DEPTH; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Expected view after a fold completes or after a pop.
   // A non-empty set shows its lowest member and its size.
   // An empty set produces one done pulse.
   task automatic expect_from(input logic [DEPTH-1:0] v);
      if (v != '0) begin
         exp_q.push_back({8'(lowest_of(v)), 8'($countones(v))});
         m_ready = 1'b1;
      end else begin
         exp_done_cnt++;
         m_ready = 1'b0;
      end
   endtask

   // ---------------- monitor ----------------
   logic pop_seen = 1'b0;
   logic prev_valid = 1'b0;

   always @(posedge clk) pop_seen <= next_req & match_valid;

   always @(negedge clk) begin
      logic [15:0] e;
      if (rstIn) begin
         if (match_valid && (!prev_valid || pop_seen)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pres_unexpected: got addr=%0d cnt=%0d expected none", match_addr, match_cnt);
            end else begin
               e = exp_q.pop_front();
               if ({match_addr, match_cnt} !== e || any_match !== 1'b1) begin
                  errors++;
                  $display("FAIL pres: got addr=%0d cnt=%0d any=%0b expected addr=%0d cnt=%0d any=1",
                           match_addr, match_cnt, any_match, e[15:8], e[7:0]);
               end
            end
         end
         if (done) begin
            checks++;
            if (exp_done_cnt == 0) begin
               errors++;
               $display("FAIL done_unexpected: got done=1 expected done=0");
            end else begin
               exp_done_cnt--;
            end
         end
      end
      prev_valid = match_valid;
   end

   // ---------------- driver tasks (entered and left on a negedge) ----------------
   task automatic accum(input logic [1:0] mode, input logic [DEPTH-1:0] row,
                        input bit complete, input bit with_pop);
      int n;
      cmp_valid = 1'b1;
      acc_mode  = mode;
      tag_row   = row;
      next_req  = with_pop;
      case (mode)
         2'b00:   m_t = row;
         2'b01:   m_t = m_t & row;
         2'b10:   m_t = m_t | row;
         default: ;
      endcase
      if (mode != 2'b11) m_ready = 1'b0;
      if (mode != 2'b11 && complete) expect_from(m_t);
      @(negedge clk);
      cmp_valid = 1'b0;
      next_req  = 1'b0;
      if (mode != 2'b11 && complete) begin
         n = 0;
         while (busy && n < 40) begin
            n++;
            @(negedge clk);
         end
         check("busy_cycles", n, 16);
         check("valid_after_count", match_valid, m_t != '0);
         check("done_after_count", done, m_t == '0);
         check("cnt_after_count", match_cnt, $countones(m_t));
      end
   endtask

   task automatic pop();
      check("valid_before_pop", match_valid, 1'b1);
      next_req = 1'b1;
      if (m_t != '0) begin
         m_t[lowest_of(m_t)] = 1'b0;
         expect_from(m_t);
      end
      @(negedge clk);
      next_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int npops;
      logic [1:0] mode;
      logic [DEPTH-1:0] row;

      rstIn = 1'b0; tag_row = '0; cmp_valid = 1'b0; acc_mode = 2'b00;
      clr_tags = 1'b0; next_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", match_valid, 0);
      check("rst_addr", match_addr, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_any", any_match, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_state", state_dbg, 0);
      rstIn = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);

      // Load then pop everything: addresses 0, 5, 10, 15, then done.
      accum(2'b00, 16'h8421, 1, 0);
      repeat (4) pop();
      check("exhaust_valid", match_valid, 0);
      check("exhaust_any", any_match, 0);
      check("exhaust_cnt", match_cnt, 0);

      // AND accumulate from READY.
      accum(2'b00, 16'hFF00, 1, 0);
      accum(2'b01, 16'h0F0F, 1, 0);

      // Empty result.
      accum(2'b00, 16'h0000, 1, 0);
      check("empty_any", any_match, 0);

      // An OR strobe in COUNT cycle 7 restarts the count.
      accum(2'b00, 16'hF000, 0, 0);
      repeat (6) @(negedge clk);
      accum(2'b10, 16'h0001, 1, 0);

      // clr_tags together with cmp_valid, taken from READY.
      clr_tags = 1'b1; cmp_valid = 1'b1; acc_mode = 2'b00; tag_row = 16'hFFFF;
      m_t = '0; m_ready = 1'b0;
      @(negedge clk);
      clr_tags = 1'b0; cmp_valid = 1'b0;
      check("clr_valid", match_valid, 0);
      check("clr_busy", busy, 0);
      check("clr_cnt", match_cnt, 0);
      check("clr_any", any_match, 0);
      check("clr_state", state_dbg, 0);
      repeat (20) @(negedge clk);
      check("clr_still_idle", busy, 0);

      // A strobe and a pop in the same READY cycle: the fold uses the un-popped T.
      accum(2'b00, 16'h00F0, 1, 0);
      accum(2'b10, 16'h0001, 1, 1);

      // Asynchronous reset mid-READY, away from any clock edge.
      accum(2'b00, 16'h0111, 1, 0);
      #2 rstIn = 1'b0;
      #1;
      check("arst_valid", match_valid, 0);
      check("arst_cnt", match_cnt, 0);
      check("arst_addr", match_addr, 0);
      check("arst_any", any_match, 0);
      check("arst_state", state_dbg, 0);
      m_t = '0; m_ready = 1'b0;
      @(negedge clk);
      rstIn = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_idle_busy", busy, 0);

      // Random traffic.
      for (int it = 0; it < 40; it++) begin
         mode = 2'($urandom_range(0, 3));
         row  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) row = row & 16'($urandom);
         if ($urandom_range(0, 7) == 0) row = '0;
         if (mode == 2'b11) begin
            accum(2'b11, row, 0, 0);
            check("hold_valid", match_valid, m_ready);
            check("hold_busy", busy, 0);
         end else begin
            accum(mode, row, 1, 0);
            npops = (m_t == '0) ? 0 : $urandom_range(0, $countones(m_t));
            repeat (npops) pop();
         end
      end

      repeat (5) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("done_all_seen", exp_done_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
